blake2_msg_loader: RTL and testbench

//  Upstream feeder for the blake2 compression core. Accepts a host byte stream (valid/ready, last flag),

---
 rtl/blake2_pkg.sv | 17 +
 rtl/blake2_msg_loader.sv | 197 +++++++++++++++++++
 tb/tb_blake2_msg_loader.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blake2_pkg.sv
// Shared constants and loader state encoding for the blake2 message loader.
package blake2_pkg;

  localparam int DEF_BB    = 128;
  localparam int DEF_LL_W  = 64;
  localparam int DEF_BLOCK = 64;
  localparam int DEF_KK_W  = 7;
  localparam int DEF_IDX_W = $clog2(DEF_BLOCK);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_STREAM    = 2'd1,
    S_PAD       = 2'd2,
    S_WAIT_CORE = 2'd3
  } loader_state_e;

endpackage

// File: rtl/blake2_msg_loader.sv
// Slices a host byte stream into zero-padded 64-byte blocks for the blake2 core,
// tracking block_first/block_last and the running message length.
module blake2_msg_loader
  import blake2_pkg::*;
#(
  parameter int BB    = DEF_BB,
  parameter int LL_W  = DEF_LL_W,
  parameter int BLOCK = DEF_BLOCK,
  parameter int KK_W  = DEF_KK_W
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [KK_W-1:0]            kk_i,
  input  logic                       in_v_i,
  input  logic [7:0]                 in_data_i,
  input  logic                       in_last_i,
  input  logic                       in_empty_i,
  output logic                       in_ready_o,
  input  logic                       core_ready_i,
  output logic                       data_v_o,
  output logic [$clog2(BLOCK)-1:0]   data_idx_o,
  output logic [7:0]                 data_o,
  output logic                       block_first_o,
  output logic                       block_last_o,
  output logic [BB-1:0]              ll_o,
  output loader_state_e              dbg_state_o
);

  localparam int IW = $clog2(BLOCK);
  localparam logic [IW-1:0] IDX_MAX = IW'(BLOCK - 1);

  // Host handshake: a byte moves when in_v_i and in_ready_o are both high in
  // the same cycle; in_ready_o is combinational and never depends on in_v_i.

  loader_state_e    state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;          // next index to emit
  logic [KK_W-1:0]  key_cnt_q, key_cnt_d;
  logic [LL_W-1:0]  ll_q, ll_d;
  logic             key_phase_q, key_phase_d;
  logic             key_blk_q, key_blk_d;
  logic             busy_seen_q, busy_seen_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             dv_q, dv_d;
  logic [7:0]       dout_q, dout_d;
  logic [IW-1:0]    didx_q, didx_d;

  logic             is_idle;
  logic             accept;
  logic             empty_acc;
  logic             take_byte;
  logic             key_req;
  logic             in_key;
  logic             key_done;
  logic             key_blk_eff;
  logic [IW-1:0]    emit_idx;
  logic [KK_W-1:0]  key_cnt_nxt;
  logic [LL_W-1:0]  ll_base;

  assign is_idle    = (state_q == S_IDLE);
  assign in_ready_o = nreset & core_ready_i & (is_idle | (state_q == S_STREAM));
  assign accept     = in_v_i & in_ready_o;
  assign empty_acc  = accept & is_idle & in_last_i & in_empty_i;
  assign take_byte  = accept & ~empty_acc;

  // The first accepted byte of a message sees a fresh context instead of the
  // registers left over from the previous message.
  assign key_req     = (kk_i != '0);
  assign emit_idx    = is_idle ? '0 : idx_q;
  assign in_key      = is_idle ? key_req : key_phase_q;
  assign key_blk_eff = is_idle ? key_req : key_blk_q;
  assign ll_base     = is_idle ? '0 : ll_q;
  assign key_cnt_nxt = (is_idle ? '0 : key_cnt_q) + KK_W'(1);
  assign key_done    = in_key & (key_cnt_nxt == kk_i);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_cnt_d   = key_cnt_q;
    ll_d        = ll_q;
    key_phase_d = key_phase_q;
    key_blk_d   = key_blk_q;
    busy_seen_d = busy_seen_q;
    first_d     = first_q;
    last_d      = last_q;
    dv_d        = 1'b0;
    dout_d      = dout_q;
    didx_d      = didx_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          first_d     = 1'b1;
          last_d      = 1'b0;
          ll_d        = '0;
          key_cnt_d   = '0;
          busy_seen_d = 1'b0;
          key_phase_d = key_req;
          key_blk_d   = key_req;
          if (empty_acc) begin
            last_d      = 1'b1;
            key_phase_d = 1'b0;
            key_blk_d   = 1'b0;
            idx_d       = '0;
            state_d     = S_PAD;
          end
        end
      end
      S_STREAM: begin
      end
      S_PAD: begin
        if (core_ready_i) begin
          dv_d   = 1'b1;
          didx_d = idx_q;
          dout_d = 8'h00;
          idx_d  = idx_q + IW'(1);
          if (idx_q == IDX_MAX) begin
            state_d = S_WAIT_CORE;
            if (key_blk_q) ll_d = ll_q + LL_W'(BLOCK);
          end
        end
      end
      S_WAIT_CORE: begin
        // The core must drop ready_v_o for at least one cycle before the
        // next block may start; busy_seen remembers that it did.
        if (!core_ready_i) busy_seen_d = 1'b1;
        if (busy_seen_q && core_ready_i) begin
          busy_seen_d = 1'b0;
          idx_d       = '0;
          key_blk_d   = 1'b0;
          first_d     = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_byte) begin
      dv_d        = 1'b1;
      didx_d      = emit_idx;
      dout_d      = in_data_i;
      idx_d       = emit_idx + IW'(1);
      key_phase_d = in_key & ~key_done;
      if (in_key) key_cnt_d = key_cnt_nxt;
      ll_d = in_key ? ll_base : ll_base + LL_W'(1);
      if (key_blk_eff && (emit_idx == IDX_MAX)) ll_d = ll_base + LL_W'(BLOCK);
      if (in_last_i) last_d = 1'b1;
      if (emit_idx == IDX_MAX)         state_d = S_WAIT_CORE;
      else if (in_last_i || key_done)  state_d = S_PAD;
      else                             state_d = S_STREAM;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      key_cnt_q   <= '0;
      ll_q        <= '0;
      key_phase_q <= 1'b0;
      key_blk_q   <= 1'b0;
      busy_seen_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      dv_q        <= 1'b0;
      dout_q      <= 8'h00;
      didx_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_cnt_q   <= key_cnt_d;
      ll_q        <= ll_d;
      key_phase_q <= key_phase_d;
      key_blk_q   <= key_blk_d;
      busy_seen_q <= busy_seen_d;
      first_q     <= first_d;
      last_q      <= last_d;
      dv_q        <= dv_d;
      dout_q      <= dout_d;
      didx_q      <= didx_d;
    end
  end

  assign data_v_o      = dv_q;
  assign data_idx_o    = didx_q;
  assign data_o        = dout_q;
  assign block_first_o = first_q;
  assign block_last_o  = last_q;
  assign ll_o          = BB'(ll_q);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_blake2_msg_loader.sv
// Bench for blake2_msg_loader: block-level reference model, reactive core model,
// directed cases plus randomized messages.
module tb_blake2_msg_loader;
  import blake2_pkg::*;

  localparam int EW = 80;  // {idx[79:74], data[73:66], first[65], last[64], ll[63:0]}

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [6:0]    kk_i = '0;
  logic          in_v_i = 1'b0;
  logic [7:0]    in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          in_empty_i = 1'b0;
  logic          in_ready_o;
  logic          core_ready_i = 1'b1;
  logic          data_v_o;
  logic [5:0]    data_idx_o;
  logic [7:0]    data_o;
  logic          block_first_o;
  logic          block_last_o;
  logic [127:0]  ll_o;
  loader_state_e dbg_state_o;

  int            errors = 0;
  int            checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    key_b[$];
  logic [7:0]    msg_b[$];
  int            blocks_seen = 0;
  bit            gap = 1'b0;
  bit            stall_en = 1'b0;
  int            busy_cnt = 0;
  longint        model_ll = 0;
  int            model_blocks = 0;

  blake2_msg_loader dut (
    .clk           (clk),
    .nreset        (nreset),
    .kk_i          (kk_i),
    .in_v_i        (in_v_i),
    .in_data_i     (in_data_i),
    .in_last_i     (in_last_i),
    .in_empty_i    (in_empty_i),
    .in_ready_o    (in_ready_o),
    .core_ready_i  (core_ready_i),
    .data_v_o      (data_v_o),
    .data_idx_o    (data_idx_o),
    .data_o        (data_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o),
    .ll_o          (ll_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- core model + compare process ----------------
  // Inputs change on the falling edge; registered outputs are compared there too,
  // before the core model updates core_ready_i for the next rising edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!nreset) begin
      core_ready_i = 1'b1;
      busy_cnt = 0;
      gap = 1'b0;
    end else begin
      if (!core_ready_i) check("in_ready_core_busy", 128'(in_ready_o), 128'(0));
      if (gap) begin
        check("in_ready_in_gap", 128'(in_ready_o), 128'(0));
        check("data_v_in_gap", 128'(data_v_o), 128'(0));
      end
      if (data_v_o) begin
        check("data_v_core_ready", 128'(core_ready_i), 128'(1));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: actual idx=%0d data=%0h required=no byte", data_idx_o, data_o);
        end else begin
          e = exp_q.pop_front();
          check("idx", 128'(data_idx_o), 128'(e[79:74]));
          check("data", 128'(data_o), 128'(e[73:66]));
          check("block_first", 128'(block_first_o), 128'(e[65]));
          if (e[79:74] == 6'd63) begin
            check("block_last", 128'(block_last_o), 128'(e[64]));
            check("ll_at_idx63", ll_o, 128'(e[63:0]));
          end
        end
        if (data_idx_o == 6'd63) begin
          blocks_seen++;
          gap = 1'b1;
          busy_cnt = $urandom_range(1, 4);
        end
      end
      if (gap) begin
        if (busy_cnt > 0) begin
          core_ready_i = 1'b0;
          busy_cnt--;
        end else begin
          core_ready_i = 1'b1;
          gap = 1'b0;
        end
      end else begin
        core_ready_i = !(stall_en && ($urandom_range(0, 7) == 0));
      end
    end
  end

  // ---------------- reference model ----------------
  // Message = optional key block (key + zeros, counts BLOCK) followed by the
  // message bytes cut into 64-byte blocks, the final one zero-padded.
  task automatic build_model(input int kk, input bit empty);
    logic [7:0]    bytes_q[$];
    longint        ll_at[$];
    longint        run;
    int            n;
    int            nb;
    logic [EW-1:0] ent;
    run = 0;
    n = msg_b.size();
    if (empty) begin
      for (int i = 0; i < 64; i++) bytes_q.push_back(8'h00);
      ll_at.push_back(0);
    end else begin
      if (kk > 0) begin
        for (int i = 0; i < 64; i++) bytes_q.push_back((i < kk) ? key_b[i] : 8'h00);
        run += 64;
        ll_at.push_back(run);
      end
      for (int b = 0; b * 64 < n; b++) begin
        for (int i = 0; i < 64; i++) bytes_q.push_back((b * 64 + i < n) ? msg_b[b * 64 + i] : 8'h00);
        run += (n - b * 64 >= 64) ? 64 : (n - b * 64);
        ll_at.push_back(run);
      end
    end
    nb = ll_at.size();
    for (int j = 0; j < nb; j++) begin
      for (int i = 0; i < 64; i++) begin
        ent = {6'(i), bytes_q[j * 64 + i], (j == 0), (j == nb - 1), 64'(ll_at[j])};
        exp_q.push_back(ent);
      end
    end
    model_ll = run;
    model_blocks = nb;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input bit last, input bit empty);
    int  t;
    bit  done;
    t = 0;
    done = 1'b0;
    in_v_i = 1'b1;
    in_data_i = d;
    in_last_i = last;
    in_empty_i = empty;
    while (!done) begin
      #1;
      if (in_ready_o) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        t++;
        if (t > 300) begin
          check("accept_timeout", 128'(in_ready_o), 128'(1));
          done = 1'b1;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    in_v_i = 1'b0;
    in_last_i = 1'b0;
    in_empty_i = 1'b0;
    in_data_i = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic fill_random(input int kk, input int n);
    key_b.delete();
    msg_b.delete();
    for (int i = 0; i < kk; i++) key_b.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < n; i++) msg_b.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic prepare(input int kk, input bit empty);
    kk_i = 7'(kk);
    blocks_seen = 0;
    build_model(kk, empty);
  endtask

  task automatic drive(input int kk, input bit empty);
    if (empty) begin
      send_byte(8'($urandom_range(1, 255)), 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < kk; i++) send_byte(key_b[i], (msg_b.size() == 0) && (i == kk - 1), 1'b0);
      for (int i = 0; i < msg_b.size(); i++) send_byte(msg_b[i], i == msg_b.size() - 1, 1'b0);
    end
  endtask

  task automatic finish_msg();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || gap) && t < 4000) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    #1;
    check("drain_queue", 128'(exp_q.size()), 128'(0));
    check("end_state", 128'(dbg_state_o), 128'(S_IDLE));
    check("end_first_cleared", 128'(block_first_o), 128'(0));
    check("end_last_cleared", 128'(block_last_o), 128'(0));
    check("ll_hold", ll_o, 128'(model_ll));
    check("block_count", 128'(blocks_seen), 128'(model_blocks));
    repeat (2) @(negedge clk);
    #1;
    check("ll_hold_idle", ll_o, 128'(model_ll));
  endtask

  task automatic run_msg(input int kk, input bit empty);
    prepare(kk, empty);
    drive(kk, empty);
    finish_msg();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  kk;
    int  n;
    bit  empty;
    bit  found;

    repeat (2) @(negedge clk);
    #1;
    check("rst_data_v", 128'(data_v_o), 128'(0));
    check("rst_in_ready", 128'(in_ready_o), 128'(0));
    check("rst_ll", ll_o, 128'(0));
    check("rst_first", 128'(block_first_o), 128'(0));
    check("rst_last", 128'(block_last_o), 128'(0));
    check("rst_idx", 128'(data_idx_o), 128'(0));
    check("rst_data", 128'(data_o), 128'(0));
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // "abc", unkeyed: pin the model and the DUT to literal values.
    key_b.delete();
    msg_b = '{8'h61, 8'h62, 8'h63};
    prepare(0, 1'b0);
    check("model_abc_len", 128'(exp_q.size()), 128'(64));
    check("model_abc_b0", 128'(exp_q[0][73:66]), 128'(8'h61));
    check("model_abc_b3", 128'(exp_q[3][73:66]), 128'(8'h00));
    drive(0, 1'b0);
    finish_msg();
    check("abc_ll_lit", ll_o, 128'(3));
    check("abc_blocks_lit", 128'(blocks_seen), 128'(1));

    fill_random(0, 64);
    run_msg(0, 1'b0);
    check("len64_ll_lit", ll_o, 128'(64));
    check("len64_blocks_lit", 128'(blocks_seen), 128'(1));

    fill_random(0, 65);
    run_msg(0, 1'b0);
    check("len65_ll_lit", ll_o, 128'(65));
    check("len65_blocks_lit", 128'(blocks_seen), 128'(2));

    fill_random(0, 0);
    run_msg(0, 1'b1);
    check("empty_ll_lit", ll_o, 128'(0));
    check("empty_blocks_lit", 128'(blocks_seen), 128'(1));

    fill_random(32, 3);
    run_msg(32, 1'b0);
    check("key32_ll_lit", ll_o, 128'(67));
    check("key32_blocks_lit", 128'(blocks_seen), 128'(2));

    // Reset while padding "abc" at idx 20, then the same message again.
    key_b.delete();
    msg_b = '{8'h61, 8'h62, 8'h63};
    prepare(0, 1'b0);
    drive(0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (data_v_o && data_idx_o == 6'd20) found = 1'b1;
    end
    check("reach_pad_idx20", 128'(found), 128'(1));
    nreset = 1'b0;
    #1;
    check("mid_rst_data_v", 128'(data_v_o), 128'(0));
    check("mid_rst_idx", 128'(data_idx_o), 128'(0));
    check("mid_rst_data", 128'(data_o), 128'(0));
    check("mid_rst_first", 128'(block_first_o), 128'(0));
    check("mid_rst_last", 128'(block_last_o), 128'(0));
    check("mid_rst_ll", ll_o, 128'(0));
    check("mid_rst_in_ready", 128'(in_ready_o), 128'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    run_msg(0, 1'b0);
    check("post_rst_ll_lit", ll_o, 128'(3));
    check("post_rst_blocks_lit", 128'(blocks_seen), 128'(1));

    // Randomized messages with core stalls.
    stall_en = 1'b1;
    for (int m = 0; m < 14; m++) begin
      kk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 64) : 0;
      n = $urandom_range(0, 140);
      if (m % 5 == 1) n = 64 * $urandom_range(1, 2);
      empty = (kk == 0) && (n == 0);
      fill_random(kk, n);
      run_msg(kk, empty);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
